// File: rtl/mc_pkg.sv
// mc_pkg: states, opcodes, ALU codes and opcode classifiers for the multicycle control unit
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH_MAR = 4'd0,
    FETCH_RD  = 4'd1,
    FETCH_IR  = 4'd2,
    DECODE    = 4'd3,
    EX_R      = 4'd4,
    EX_I      = 4'd5,
    WB_ALU    = 4'd6,
    MEM_ADDR  = 4'd7,
    MEM_RD    = 4'd8,
    MEM_WR    = 4'd9,
    WB_MEM    = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_CLZ    = 6'b011100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LBU    = 6'b100100;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_J      = 6'b000010;

  localparam logic [2:0] ALU_FUNCT   = 3'd0;
  localparam logic [2:0] ALU_CMP_EQ  = 3'd1;
  localparam logic [2:0] ALU_CMP_LEZ = 3'd2;
  localparam logic [2:0] ALU_CMP_GTZ = 3'd3;
  localparam logic [2:0] ALU_CLZ     = 3'd4;
  localparam logic [2:0] ALU_ADD     = 3'd5;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OP_LW, OP_LB, OP_LBU};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OP_SW, OP_SB};
  endfunction

  function automatic logic is_byte(input logic [5:0] op);
    return op inside {OP_LB, OP_LBU, OP_SB};
  endfunction

  function automatic logic is_unsigned(input logic [5:0] op);
    return op inside {OP_LBU, OP_ADDIU};
  endfunction

  // FETCH_MAR doubles as the illegal-opcode target
  function automatic state_t decode_next(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_CLZ} ? EX_R :
           op inside {OP_ADDI, OP_ADDIU} ? EX_I :
           (is_load(op) || is_store(op)) ? MEM_ADDR :
           op inside {OP_BEQ, OP_REGIMM, OP_BLEZ, OP_BGTZ} ? BRANCH :
           op == OP_J ? JUMP : FETCH_MAR;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles and flags the cycle that exhausts the budget
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  input  logic mem_ready,
  output logic timeout
);
  logic [TMO_W-1:0] cnt;
  // cleared outside memory states so every access starts from zero
  always_ff @(posedge clk)
    if (!reset || !busy) cnt <= '0;
    else if (!mem_ready) cnt <= cnt + TMO_W'(1);
  assign timeout = busy && !mem_ready && cnt == TMO_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the MIPS-subset datapath
module multicycle_control
  import mc_pkg::*;
#(
  parameter int ALU_CODE_W = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic                  cond_true,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_rw,
  output logic                  mar_load,
  output logic                  mdr_load,
  output logic                  ir_load,
  output logic                  pc_load,
  output logic [1:0]            pc_src,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  flag_load,
  output logic [1:0]            alu_src,
  output logic [ALU_CODE_W-1:0] alu_code,
  output logic                  byte_op,
  output logic                  unsigned_op,
  output logic                  illegal,
  output logic                  bus_error,
  output logic [3:0]            state_dbg
);
  state_t state;
  logic [5:0] op_q, cur_op;
  logic busy, timeout, in_fetch;

  assign busy = state inside {FETCH_RD, MEM_RD, MEM_WR};
  assign in_fetch = state inside {FETCH_MAR, FETCH_RD, FETCH_IR};
  assign cur_op = state == DECODE ? opcode : op_q;
  assign state_dbg = state;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .busy(busy),
    .mem_ready(mem_ready),
    .timeout(timeout)
  );

  // state sequencing and opcode capture; ready beats timeout in memory states
  always_ff @(posedge clk)
    if (!reset) begin
      state <= FETCH_MAR;
      op_q <= '0;
    end else begin
      if (state == DECODE) op_q <= opcode;
      case (state)
        FETCH_MAR: state <= FETCH_RD;
        FETCH_RD:  state <= mem_ready ? FETCH_IR : timeout ? FETCH_MAR : FETCH_RD;
        FETCH_IR:  state <= DECODE;
        DECODE:    state <= decode_next(opcode);
        EX_R:      state <= WB_ALU;
        EX_I:      state <= WB_ALU;
        MEM_ADDR:  state <= is_load(op_q) ? MEM_RD : MEM_WR;
        MEM_RD:    state <= mem_ready ? WB_MEM : timeout ? FETCH_MAR : MEM_RD;
        MEM_WR:    state <= (mem_ready || timeout) ? FETCH_MAR : MEM_WR;
        default:   state <= FETCH_MAR;
      endcase
    end

  // per-state control outputs, all forced low while reset is held
  always_comb begin
    mem_req = 1'b0;
    mem_rw = 1'b0;
    mar_load = 1'b0;
    mdr_load = 1'b0;
    ir_load = 1'b0;
    pc_load = 1'b0;
    pc_src = 2'd0;
    reg_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    flag_load = 1'b0;
    alu_src = 2'd0;
    alu_code = ALU_CODE_W'(ALU_FUNCT);
    illegal = 1'b0;
    bus_error = 1'b0;
    byte_op = reset && !in_fetch && is_byte(cur_op);
    unsigned_op = reset && !in_fetch && is_unsigned(cur_op);
    if (reset)
      case (state)
        FETCH_MAR: mar_load = 1'b1;
        FETCH_RD: begin
          mem_req = 1'b1;
          mem_rw = 1'b1;
          bus_error = timeout;
        end
        FETCH_IR: begin
          ir_load = 1'b1;
          pc_load = 1'b1;
        end
        DECODE: illegal = decode_next(opcode) == FETCH_MAR;
        EX_R: begin
          flag_load = 1'b1;
          alu_code = ALU_CODE_W'(op_q == OP_CLZ ? ALU_CLZ : ALU_FUNCT);
        end
        EX_I: begin
          flag_load = 1'b1;
          alu_src = op_q == OP_ADDIU ? 2'd2 : 2'd1;
          alu_code = ALU_CODE_W'(ALU_ADD);
        end
        WB_ALU: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
          reg_dst = op_q inside {OP_RTYPE, OP_CLZ};
        end
        MEM_ADDR: begin
          mar_load = 1'b1;
          alu_src = 2'd1;
          alu_code = ALU_CODE_W'(ALU_ADD);
        end
        MEM_RD: begin
          mem_req = 1'b1;
          mem_rw = 1'b1;
          mdr_load = mem_ready;
          bus_error = timeout;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          bus_error = timeout;
        end
        WB_MEM: reg_write = 1'b1;
        BRANCH: begin
          pc_load = cond_true;
          pc_src = 2'd1;
          alu_code = ALU_CODE_W'(op_q == OP_BLEZ ? ALU_CMP_LEZ : op_q == OP_BGTZ ? ALU_CMP_GTZ : ALU_CMP_EQ);
        end
        JUMP: begin
          pc_load = 1'b1;
          pc_src = 2'd2;
        end
        default: ;
      endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven cycle-by-cycle check of the multicycle control unit
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic cond_true = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_rw, mar_load, mdr_load, ir_load, pc_load;
  logic [1:0] pc_src, alu_src;
  logic reg_write, reg_dst, mem_to_reg, flag_load;
  logic [5:0] alu_code;
  logic byte_op, unsigned_op, illegal, bus_error;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control #(.ALU_CODE_W(6), .MEM_TIMEOUT(15), .TMO_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .opcode(opcode),
    .cond_true(cond_true),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .mem_rw(mem_rw),
    .mar_load(mar_load),
    .mdr_load(mdr_load),
    .ir_load(ir_load),
    .pc_load(pc_load),
    .pc_src(pc_src),
    .reg_write(reg_write),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .flag_load(flag_load),
    .alu_src(alu_src),
    .alu_code(alu_code),
    .byte_op(byte_op),
    .unsigned_op(unsigned_op),
    .illegal(illegal),
    .bus_error(bus_error),
    .state_dbg(state_dbg)
  );

  localparam logic [13:0] MAR = 14'h0001, MDR = 14'h0002, IR = 14'h0004, PCL = 14'h0008;
  localparam logic [13:0] RW = 14'h0010, RD = 14'h0020, M2R = 14'h0040, FL = 14'h0080;
  localparam logic [13:0] BYT = 14'h0100, UNS = 14'h0200, ILL = 14'h0400, BERR = 14'h0800;
  localparam logic [13:0] REQ = 14'h1000, RDN = 14'h2000;
  localparam logic [3:0] ANY = 4'hf;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, LB = 6'b100000, SW = 6'b101011, SB = 6'b101000;
  localparam logic [5:0] BEQ = 6'b000100, BGTZ = 6'b000111, ADDIU = 6'b001001, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic rst;
    logic [5:0] op;
    logic ct;
    logic rdy;
    logic [3:0] st;
    logic [13:0] ctl;
    logic [1:0] pcs;
    logic [1:0] as;
    logic [2:0] alu;
  } vec_t;

  vec_t v[$];
  int errors = 0;
  int checks = 0;

  task automatic add(input logic rst, input logic [5:0] op, input logic ct, input logic rdy,
                     input logic [3:0] st, input logic [13:0] ctl,
                     input logic [1:0] pcs = 2'd0, input logic [1:0] as = 2'd0, input logic [2:0] alu = 3'd0);
    v.push_back('{rst, op, ct, rdy, st, ctl, pcs, as, alu});
  endtask

  task automatic fetch3(input logic [5:0] op);
    add(1, op, 0, 1, 0, MAR);
    add(1, op, 0, 1, 1, REQ | RDN);
    add(1, op, 0, 1, 2, IR | PCL);
  endtask

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d ctl=%h pcs=%0d as=%0d alu=%0d, expected st=%0d ctl=%h pcs=%0d as=%0d alu=%0d",
               name, got[27:24], got[23:10], got[9:8], got[7:6], got[5:0],
               exp[27:24], exp[23:10], exp[9:8], exp[7:6], exp[5:0]);
    end
  endtask

  initial begin
    logic [27:0] got, exp;
    int n;
    bit done, byte_wb;
    // reset for two cycles, then an R-type
    add(0, R, 0, 1, ANY, 0);
    add(0, R, 0, 1, 0, 0);
    fetch3(R);
    add(1, R, 0, 1, 3, 0);
    add(1, R, 0, 1, 4, FL);
    add(1, R, 0, 1, 6, RW | RD | M2R);
    // LW with three wait cycles on the data read; mem_ready low outside memory is ignored
    add(1, LW, 0, 1, 0, MAR);
    add(1, LW, 0, 1, 1, REQ | RDN);
    add(1, LW, 0, 0, 2, IR | PCL);
    add(1, LW, 0, 0, 3, 0);
    add(1, LW, 0, 0, 7, MAR, 0, 1, 5);
    for (int i = 0; i < 3; i++) add(1, LW, 0, 0, 8, REQ | RDN);
    add(1, LW, 0, 1, 8, REQ | RDN | MDR);
    add(1, LW, 0, 0, 10, RW);
    // BEQ not taken then taken, BGTZ taken
    fetch3(BEQ);
    add(1, BEQ, 0, 1, 3, 0);
    add(1, BEQ, 0, 1, 11, 0, 1, 0, 1);
    fetch3(BEQ);
    add(1, BEQ, 1, 1, 3, 0);
    add(1, BEQ, 1, 1, 11, PCL, 1, 0, 1);
    fetch3(BGTZ);
    add(1, BGTZ, 1, 1, 3, 0);
    add(1, BGTZ, 1, 1, 11, PCL, 1, 0, 3);
    // ADDIU: zero-extended immediate, unsigned held through writeback
    fetch3(ADDIU);
    add(1, ADDIU, 0, 1, 3, UNS);
    add(1, ADDIU, 0, 1, 5, UNS | FL, 0, 2, 5);
    add(1, ADDIU, 0, 1, 6, UNS | RW | M2R);
    // jump
    fetch3(J);
    add(1, J, 0, 1, 3, 0);
    add(1, J, 0, 1, 12, PCL, 2);
    // illegal opcode
    fetch3(BAD);
    add(1, BAD, 0, 1, 3, ILL);
    // fetch never answered: bus error on the 15th waiting cycle
    add(1, R, 0, 0, 0, MAR);
    for (int i = 0; i < 14; i++) add(1, R, 0, 0, 1, REQ | RDN);
    add(1, R, 0, 0, 1, REQ | RDN | BERR);
    // ready arriving on the timeout cycle wins
    add(1, J, 0, 0, 0, MAR);
    for (int i = 0; i < 14; i++) add(1, J, 0, 0, 1, REQ | RDN);
    add(1, J, 0, 1, 1, REQ | RDN);
    add(1, J, 0, 0, 2, IR | PCL);
    add(1, J, 0, 0, 3, 0);
    add(1, J, 0, 0, 12, PCL, 2);
    // SW completing immediately
    fetch3(SW);
    add(1, SW, 0, 1, 3, 0);
    add(1, SW, 0, 1, 7, MAR, 0, 1, 5);
    add(1, SW, 0, 1, 9, REQ);
    // SB abandoned by reset during the write
    fetch3(SB);
    add(1, SB, 0, 1, 3, BYT);
    add(1, SB, 0, 1, 7, MAR | BYT, 0, 1, 5);
    add(1, SB, 0, 0, 9, REQ | BYT);
    add(0, SB, 0, 0, 9, 0);
    add(1, SB, 0, 0, 0, MAR);

    for (int i = 0; i < v.size(); i++) begin
      @(posedge clk);
      #1;
      reset = v[i].rst;
      opcode = v[i].op;
      cond_true = v[i].ct;
      mem_ready = v[i].rdy;
      @(negedge clk);
      got = {state_dbg, mem_rw, mem_req, bus_error, illegal, unsigned_op, byte_op, flag_load,
             mem_to_reg, reg_dst, reg_write, pc_load, ir_load, mdr_load, mar_load, pc_src, alu_src, alu_code};
      if (v[i].st == ANY) got[27:24] = ANY;
      exp = {v[i].st, v[i].ctl, v[i].pcs, v[i].as, 3'b000, v[i].alu};
      check($sformatf("vec%0d", i), got, exp);
    end

    // LB latency from a fresh reset, bounded wait for return to FETCH_MAR
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    opcode = LB;
    mem_ready = 1'b1;
    n = 0;
    done = 0;
    byte_wb = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      n++;
      if (state_dbg == 4'd10 && byte_op && reg_write) byte_wb = 1;
      @(posedge clk);
      #1;
      if (state_dbg == 4'd0) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL lb_return: state_dbg=%0d after 20 cycles, required 0", state_dbg);
    end
    checks++;
    if (n != 7) begin
      errors++;
      $display("FAIL lb_latency: got %0d cycles, required 7", n);
    end
    checks++;
    if (!byte_wb) begin
      errors++;
      $display("FAIL lb_byte_wb: byte_op with reg_write in WB_MEM got 0, required 1");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multicycle control unit for the single-issue MIPS-subset datapath. It replaces the flat combinational opcode decoder with an explicit fetch/decode/execute/memory/writeback state machine. Memory accesses use a req/ready handshake with a bounded wait-state counter. The unit drives the datapath load enables (MAR, MDR, IR, PC, register file, flags) and the ALU/mux selects.

## Interface
Parameters:
- ALU_CODE_W, 6, width of `alu_code`; ALU codes are zero-extended into it
- MEM_TIMEOUT, 15, maximum cycles spent waiting for `mem_ready` before a bus error; must be ≥1
- TMO_W, 4, width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-low reset (sampled on `clk` rising edge)
- opcode  in  6  IR[31:26]; sampled only in DECODE
- cond_true  in  1  branch condition from the ALU flags, valid in BRANCH
- mem_ready  in  1  memory completion for the current request
- mem_req  out  1  memory request, held until `mem_ready` or timeout
- mem_rw  out  1  1 = read, 0 = write; valid while `mem_req` is high
- mar_load, mdr_load, ir_load  out  1 each  datapath register load enables
- pc_load  out  1  PC write enable
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = reserved (never driven)
- reg_write, reg_dst, mem_to_reg, flag_load  out  1 each  register-file and flag controls
- alu_src  out  2  0 = rt, 1 = sign-extended immediate, 2 = zero-extended immediate, 3 = PC
- alu_code  out  ALU_CODE_W  ALU operation
- byte_op, unsigned_op  out  1 each  byte-sized access / zero-extension qualifiers
- illegal, bus_error  out  1 each  one-cycle fault pulses
- state_dbg  out  4  current state encoding

## Operation
- States:
  - FETCH_MAR(0): mar_load=1 → FETCH_RD.
  - FETCH_RD(1): mem_req=1, mem_rw=1; on mem_ready → FETCH_IR.
  - FETCH_IR(2): ir_load=1, pc_load=1, pc_src=0 → DECODE.
  - DECODE(3): latch opcode into op_q, then dispatch:
    - 000000 → EX_R.
    - 011100 → EX_R with alu_code=CLZ.
    - 001000/001001 → EX_I.
    - 100011/100000/100100/101011/101000 → MEM_ADDR.
    - 000100/000001/000110/000111 → BRANCH.
    - 000010 → JUMP.
    - anything else → FETCH_MAR with illegal=1.
  - EX_R(4): alu_src=0, flag_load=1 → WB_ALU.
  - EX_I(5): alu_src=1 for 001000, 2 for 001001; alu_code=ADD; unsigned_op per opcode; flag_load=1 → WB_ALU.
  - WB_ALU(6): reg_write=1, mem_to_reg=1; reg_dst=1 only for R-type/CLZ → FETCH_MAR.
  - MEM_ADDR(7): alu_src=1, alu_code=ADD, mar_load=1 → MEM_RD for loads, MEM_WR for stores.
  - MEM_RD(8): mem_req=1, mem_rw=1, mdr_load=1 on the ready cycle → WB_MEM.
  - MEM_WR(9): mem_req=1, mem_rw=0 → FETCH_MAR.
  - WB_MEM(10): reg_write=1, mem_to_reg=0, reg_dst=0 → FETCH_MAR.
  - BRANCH(11): alu_code=CMP_EQ/CMP_EQ/CMP_LEZ/CMP_GTZ; pc_load=cond_true, pc_src=1 → FETCH_MAR.
  - JUMP(12): pc_load=1, pc_src=2 → FETCH_MAR.
- byte_op=1 for 100000/100100/101000; unsigned_op=1 for 100100/001001, both held from DECODE until return to FETCH_MAR.
- All outputs not listed for a state are 0; alu_code defaults to FUNCT (0); alu_src defaults to 0.
- Wait counter: cleared on entry to any memory state, increments each cycle with mem_req high and mem_ready low. On reaching MEM_TIMEOUT: bus_error=1, mem_req drops, next state FETCH_MAR, no load enable asserted.
- mem_ready outside a memory state is ignored.

## Timing
- Outputs are Moore functions of the registered state plus op_q, with no output registers; `state_dbg` equals the state register.
- Latency with mem_ready high on the first request cycle:
  - R-type/ALU-imm: 6 cycles.
  - Load: 7 cycles.
  - Store: 6 cycles.
  - Branch and jump: 5 cycles.
  - Illegal: 4 cycles.
  - Each wait cycle adds 1.
- Reset: reset low at a rising edge forces FETCH_MAR, clears op_q and the counter, and drives all outputs to 0 (except state_dbg=0) that cycle and the next. The first mar_load follows in the first cycle with reset high. Reset mid-access abandons the request; mem_req is 0 in the cycle after the reset edge.
- mem_ready and timeout in the same cycle: ready wins, no bus_error.

## Structure
- Package `mc_pkg`: state enum, opcode localparams, and ALU code localparams (FUNCT=0, CMP_EQ=1, CMP_LEZ=2, CMP_GTZ=3, CLZ=4, ADD=5).
- One sub-module, `mem_wait_timer`, holds the wait counter and timeout compare. Everything else stays in `multicycle_control`.

## Test plan
- Reset low for 2 cycles with opcode 000000 and mem_ready=1 → all outputs 0; then states 0,1,2,3,4,6,0 with reg_write, reg_dst and mem_to_reg high in cycle 6.
- LW (100011) with mem_ready delayed 3 cycles on the data read → mdr_load on the ready cycle only, then WB_MEM with reg_write=1, mem_to_reg=0; 10 cycles total.
- BEQ (000100) run twice, once with cond_true=0 and once with cond_true=1 → pc_load stays 0 in BRANCH, then pc_load=1 with pc_src=1.
- Opcode 111111 → illegal pulses for one cycle in DECODE and the next state is FETCH_MAR.
- mem_ready never asserted in FETCH_RD with MEM_TIMEOUT=15 → bus_error on the 15th waiting cycle, mem_req low in the next cycle, state 0.
- SB (101000) with reset pulsed low during MEM_WR → byte_op=1 before the reset; mem_req=0 in the cycle after the reset edge; state 0.
